prog_reader: RTL and testbench
==============================

# prog_reader

Read-side consumer for the program FIFO. Each FIFO entry holds a data word plus a repeat count. The block pops one entry at a time, latches it, and replays the word `count` times on a valid/ready output stream, tagging each beat with its repetition index and a last flag. It sits between the program FIFO and the downstream datapath, and is the drain end of the new/inc/dec program bookkeeping.

## Interface
- `D_WIDTH`, 31, width of the data word
- `CNT_WIDTH`, 8, width of the repeat count and the repetition index
- `clk`  in  1  clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `enable`  in  1  allows new entries to be fetched; does not abort an entry in progress
- `flush`  in  1  drops the current entry and returns to IDLE
- `fifo_q`  in  D_WIDTH  data word at the FIFO tail
- `fifo_cnt`  in  CNT_WIDTH  repeat count at the FIFO tail
- `fifo_empty`  in  1  FIFO has no entries
- `fifo_pop`  out  1  one-cycle pop strobe; advances the FIFO tail
- `out_valid`  out  1  output beat available
- `out_ready`  in  1  downstream accepts the beat
- `out_data`  out  D_WIDTH  latched data word
- `out_idx`  out  CNT_WIDTH  repetition index, 0..cnt-1
- `out_last`  out  1  beat is the final repetition of its entry
- `err_zero`  out  1  sticky flag; an entry with count 0 was seen
- `entries_done`  out  16  count of fully issued entries; wraps modulo 2^16

## Operation
- There are three states: IDLE, LOAD and ISSUE.
- **IDLE:** if `enable & ~fifo_empty`, go to LOAD.
- **LOAD (one cycle):**
  - `fifo_pop=1`.
  - Capture `fifo_q` into `data_r` and `fifo_cnt` into `cnt_r`.
  - Set `rep=0`.
  - If `fifo_cnt==0`: set `err_zero`, produce no beat, and go to IDLE.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `out_valid=1`, `out_data=data_r`, `out_idx=rep`, `out_last=(rep==cnt_r-1)`.
  - A handshake is `out_valid & out_ready`.
  - On a handshake with `~out_last`: `rep<=rep+1` and stay in ISSUE.
  - On a handshake with `out_last`:
    - `entries_done++`.
    - If `enable & ~fifo_empty`, go to LOAD; otherwise go to IDLE.
- **Output stability:** while `out_valid=1` and `out_ready=0`, `out_data`, `out_idx` and `out_last` hold.
- **flush:** from any state, go to IDLE next cycle.
  - `fifo_pop` is not asserted in that cycle, even from LOAD.
  - The partially issued entry is discarded and `entries_done` is unchanged.
  - `flush` has priority over all other transitions.
- **enable deasserted in ISSUE:** the current entry completes, then the block parks in IDLE.
- **Count arithmetic:** the count is unsigned in CNT_WIDTH. `cnt=2^CNT_WIDTH-1` gives indices 0..254 at CNT_WIDTH=8. `rep` never wraps within an entry.
- **FIFO side:** `fifo_q`/`fifo_cnt` are sampled only in LOAD. `fifo_pop` is never asserted when `fifo_empty=1`.
- **err_zero:** cleared only by reset.

## Timing
- **Reset (`reset=0` at a clock edge):**
  - State becomes IDLE.
  - `fifo_pop`, `out_valid`, `out_last` and `err_zero` are 0.
  - `out_data`, `out_idx` and `entries_done` are 0.
  - Reset mid-ISSUE abandons the entry with no pop.
- **Latency:** `fifo_empty` falls at cycle N with `enable=1` → LOAD at N+1 (pop) → first `out_valid` at N+2.
- **Throughput:** one beat per cycle within an entry. Between back-to-back entries there is exactly one bubble cycle (the LOAD cycle).
- `fifo_pop` is high in the LOAD cycle only. The FIFO updates its tail on the same edge that ends LOAD.
- `out_*` outputs are driven from registers/state only. There is no combinational path from `out_ready` to `out_valid`.

## Structure
- **Shared package `prog_pkg`:**
  - state enum `{IDLE, LOAD, ISSUE}`.
  - `CNT_WIDTH_DEF=8`.
  - `ENTRIES_W=16`.
  - The package is shared with the FIFO so `fifo_cnt` width matches.
- **Single module, no sub-module:**
  - The repetition counter and the entry counter are simple registers.
  - The state machine is one always block plus a next-state block.

## Test plan
- Entries (0xA,3), FIFO then empty, `out_ready=1` → beats A/idx0, A/idx1, A/idx2 (last). One pop. `entries_done=1`. Back to IDLE.
- Entries (0x1,1) and (0x2,2) back-to-back → beats 1/0/last, bubble, 2/0, 2/1/last. Exactly two pops. `entries_done=2`.
- (0x5,2) with `out_ready` low for 4 cycles on beat 0 → `out_data=5`, `idx=0` held stable. Then idx0 and idx1 complete with no loss or duplication.
- Entry (0x7,0) followed by (0x8,1) → `err_zero=1`. Only beat 8/0/last is emitted. Two pops.
- (0x9,4) with `flush` after idx1 accepted → IDLE next cycle. No further beats and no extra pop. `entries_done` unchanged. `reset=0` mid-ISSUE gives all outputs 0.
- `enable=0` asserted during idx0 of (0x3,2) with a second entry queued → both beats of 3 are issued, then IDLE with no pop until `enable=1`.

Source files
------------

// File: rtl/prog_pkg.sv
// prog_pkg: definitions shared by the program FIFO and its read-side consumer.
//   state_t        : reader state encoding (IDLE, LOAD, ISSUE)
//   CNT_WIDTH_DEF  : default width of the repeat count / repetition index
//   ENTRIES_W      : width of the completed-entry counter
package prog_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam int CNT_WIDTH_DEF = 8;
  localparam int ENTRIES_W     = 16;

endpackage

// File: rtl/prog_reader.sv
// prog_reader: pops {word, repeat count} entries from the program FIFO and
// replays each word `count` times on a valid/ready stream.
// Ports:
//   clk, reset (sync, active-low)
//   enable        : allows fetching new entries (never aborts one in progress)
//   flush         : drops the current entry, returns to IDLE (highest priority)
//   fifo_q/fifo_cnt/fifo_empty : FIFO tail view;  fifo_pop : one-cycle pop strobe
//   out_valid/out_ready/out_data/out_idx/out_last : replay stream
//   err_zero      : sticky, a zero-count entry was popped
//   entries_done  : number of fully issued entries (wraps)
module prog_reader
  import prog_pkg::*;
#(
  parameter int D_WIDTH   = 31,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic [D_WIDTH-1:0]   fifo_q,
  input  logic [CNT_WIDTH-1:0] fifo_cnt,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D_WIDTH-1:0]   out_data,
  output logic [CNT_WIDTH-1:0] out_idx,
  output logic                 out_last,
  output logic                 err_zero,
  output logic [ENTRIES_W-1:0] entries_done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ENTRIES_W-1:0] DONE_ONE = ENTRIES_W'(1);

  state_t               r_state;
  state_t               w_state_next;
  logic [D_WIDTH-1:0]   r_data;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_rep;
  logic                 r_err;
  logic [ENTRIES_W-1:0] r_done;
  logic                 w_last;
  logic                 w_hs;
  logic                 w_fetch;

  // r_cnt is non-zero whenever ISSUE is active, so cnt-1 never underflows there.
  assign w_last    = (r_state == ISSUE) && (r_rep == (r_cnt - CNT_ONE));
  assign w_hs      = (r_state == ISSUE) && out_ready;
  assign w_fetch   = enable && !fifo_empty;

  assign out_valid    = (r_state == ISSUE);
  assign out_data     = r_data;
  assign out_idx      = r_rep;
  assign out_last     = w_last;
  assign err_zero     = r_err;
  assign entries_done = r_done;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    fifo_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fetch) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        // The tail cannot drain without our pop, but guard anyway so a pop
        // is never issued against an empty FIFO.
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          w_state_next = (fifo_cnt == '0) ? IDLE : ISSUE;
        end else begin
          w_state_next = IDLE;
        end
      end
      ISSUE: begin
        if (w_hs && w_last) begin
          w_state_next = w_fetch ? LOAD : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (flush) begin
      w_state_next = IDLE;
      fifo_pop     = 1'b0;
    end
  end

  // fifo_pop already folds in flush, so a flushed LOAD captures nothing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_rep  <= '0;
      r_err  <= 1'b0;
      r_done <= '0;
    end else if (fifo_pop) begin
      r_data <= fifo_q;
      r_cnt  <= fifo_cnt;
      r_rep  <= '0;
      if (fifo_cnt == '0) begin
        r_err <= 1'b1;
      end
    end else if (w_hs && !flush) begin
      if (w_last) begin
        r_done <= r_done + DONE_ONE;
      end else begin
        r_rep <= r_rep + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_prog_reader.sv
// tb_prog_reader: directed scenarios plus a randomized run of prog_reader,
// with a queue-based FIFO model and an expected beat stream built from the
// entries pushed.
module tb_prog_reader;

  typedef struct {
    logic [30:0] d;
    logic [7:0]  c;
  } entry_t;

  typedef struct {
    logic [30:0] d;
    logic [7:0]  i;
    logic        l;
    int          cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [30:0] fifo_q = '0;
  logic [7:0]  fifo_cnt = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_pop;
  logic        out_valid;
  logic [30:0] out_data;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        err_zero;
  logic [15:0] entries_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pops = 0;
  int pop_on_empty = 0;
  int stab_err = 0;
  int exp_done = 0;
  bit pop_pending = 0;
  bit prev_stall = 0;
  logic [30:0] prev_d;
  logic [7:0]  prev_i;
  logic        prev_l;

  entry_t fq[$];
  beat_t  obs[$];
  beat_t  expq[$];

  prog_reader #(.D_WIDTH(31), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .fifo_q(fifo_q), .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .err_zero(err_zero), .entries_done(entries_done)
  );

  always #5 clk = ~clk;

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_q     = (fq.size() != 0) ? fq[0].d : '0;
    fifo_cnt   = (fq.size() != 0) ? fq[0].c : '0;
  endfunction

  // Sample everything mid-cycle: these are the values the next edge will see.
  always @(negedge clk) begin
    pop_pending = reset && fifo_pop;
    if (reset && fifo_pop && fifo_empty) pop_on_empty++;
    if (reset && !flush && out_valid && out_ready)
      obs.push_back('{d: out_data, i: out_idx, l: out_last, cyc: cyc});
    if (prev_stall && out_valid &&
        (out_data !== prev_d || out_idx !== prev_i || out_last !== prev_l))
      stab_err++;
    prev_stall = reset && !flush && out_valid && !out_ready;
    prev_d = out_data; prev_i = out_idx; prev_l = out_last;
  end

  // FIFO model: tail advances on the edge that ends a popping cycle.
  always @(posedge clk) begin
    cyc++;
    if (pop_pending) begin
      pops++;
      if (fq.size() != 0) void'(fq.pop_front());
    end
    #1 refresh();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [30:0] d, input logic [7:0] c);
    fq.push_back('{d: d, c: c});
    refresh();
  endtask

  task automatic wait_obs(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin tick(); k++; end
    if (obs.size() < n) begin
      $display("FAIL %s timeout: beats seen %0d, required %0d", nm, obs.size(), n);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic wait_valid(input int budget, input string nm);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < budget) begin tick(); k++; end
    if (out_valid !== 1'b1) begin
      $display("FAIL %s timeout waiting for out_valid", nm);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic check_beat(input int k, input logic [30:0] d, input logic [7:0] i,
                            input logic l, input string nm);
    if (k >= obs.size()) begin
      $display("FAIL %s beat%0d missing", nm, k);
      n_err++;
    end else if (obs[k].d !== d || obs[k].i !== i || obs[k].l !== l) begin
      $display("FAIL %s beat%0d got d=%h i=%0d l=%b, required d=%h i=%0d l=%b",
               nm, k, obs[k].d, obs[k].i, obs[k].l, d, i, l);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic check_int(input int got, input int req, input string nm);
    if (got !== req) begin
      $display("FAIL %s got %0d required %0d", nm, got, req);
      n_err++;
    end
    n_vec++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fq.delete();
    refresh();
    tick(); tick();
    reset = 1'b1;
    obs.delete();
    exp_done = 0;
  endtask

  task automatic test_reset();
    enable = 1'b1; out_ready = 1'b1; flush = 1'b0;
    do_reset();
    check_int({31'd0, out_valid}, 0, "reset out_valid");
    check_int({31'd0, fifo_pop}, 0, "reset fifo_pop");
    check_int({31'd0, out_last}, 0, "reset out_last");
    check_int({31'd0, err_zero}, 0, "reset err_zero");
    check_int({1'b0, out_data}, 0, "reset out_data");
    check_int({24'd0, out_idx}, 0, "reset out_idx");
    check_int({16'd0, entries_done}, 0, "reset entries_done");
  endtask

  task automatic test_single();
    int p0;
    p0 = pops; obs.delete();
    push(31'hA, 8'd3);
    tick();
    check_int({31'd0, fifo_pop}, 1, "single pop in LOAD");
    check_int({31'd0, out_valid}, 0, "single no valid in LOAD");
    tick();
    check_int({31'd0, out_valid}, 1, "single first valid latency");
    wait_obs(3, 20, "single");
    tick(); tick(); tick();
    check_beat(0, 31'hA, 8'd0, 1'b0, "single");
    check_beat(1, 31'hA, 8'd1, 1'b0, "single");
    check_beat(2, 31'hA, 8'd2, 1'b1, "single");
    check_int(obs.size(), 3, "single beat count");
    check_int(pops - p0, 1, "single pops");
    exp_done += 1;
    check_int({16'd0, entries_done}, exp_done, "single entries_done");
    check_int({31'd0, out_valid}, 0, "single idle");
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pops; obs.delete();
    push(31'h1, 8'd1);
    push(31'h2, 8'd2);
    wait_obs(3, 30, "b2b");
    tick(); tick(); tick();
    check_beat(0, 31'h1, 8'd0, 1'b1, "b2b");
    check_beat(1, 31'h2, 8'd0, 1'b0, "b2b");
    check_beat(2, 31'h2, 8'd1, 1'b1, "b2b");
    if (obs.size() >= 3) begin
      check_int(obs[1].cyc - obs[0].cyc, 2, "b2b one bubble");
      check_int(obs[2].cyc - obs[1].cyc, 1, "b2b full rate");
    end
    check_int(pops - p0, 2, "b2b pops");
    exp_done += 2;
    check_int({16'd0, entries_done}, exp_done, "b2b entries_done");
  endtask

  task automatic test_stall();
    int p0;
    p0 = pops; obs.delete();
    out_ready = 1'b0;
    push(31'h5, 8'd2);
    wait_valid(20, "stall");
    for (int k = 0; k < 4; k++) begin
      if (out_valid !== 1'b1 || out_data !== 31'h5 || out_idx !== 8'd0 || out_last !== 1'b0) begin
        $display("FAIL stall hold cyc%0d got v=%b d=%h i=%0d l=%b, required v=1 d=5 i=0 l=0",
                 k, out_valid, out_data, out_idx, out_last);
        n_err++;
      end
      n_vec++;
      tick();
    end
    out_ready = 1'b1;
    wait_obs(2, 20, "stall");
    tick(); tick(); tick();
    check_beat(0, 31'h5, 8'd0, 1'b0, "stall");
    check_beat(1, 31'h5, 8'd1, 1'b1, "stall");
    check_int(obs.size(), 2, "stall no dup");
    check_int(pops - p0, 1, "stall pops");
    exp_done += 1;
    check_int({16'd0, entries_done}, exp_done, "stall entries_done");
  endtask

  task automatic test_zero();
    int p0;
    p0 = pops; obs.delete();
    push(31'h7, 8'd0);
    push(31'h8, 8'd1);
    wait_obs(1, 30, "zero");
    tick(); tick(); tick(); tick();
    check_int({31'd0, err_zero}, 1, "zero err_zero");
    check_int(obs.size(), 1, "zero beat count");
    check_beat(0, 31'h8, 8'd0, 1'b1, "zero");
    check_int(pops - p0, 2, "zero pops");
    exp_done += 1;
    check_int({16'd0, entries_done}, exp_done, "zero entries_done");
  endtask

  task automatic test_flush();
    int p0;
    p0 = pops; obs.delete();
    push(31'h9, 8'd4);
    wait_obs(2, 20, "flush");
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    check_int({31'd0, out_valid}, 0, "flush idle next cycle");
    for (int k = 0; k < 5; k++) tick();
    check_int(obs.size(), 2, "flush no further beats");
    check_int(pops - p0, 1, "flush pops");
    check_int({16'd0, entries_done}, exp_done, "flush entries_done");
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pops; obs.delete();
    out_ready = 1'b0;
    push(31'hB, 8'd3);
    wait_valid(20, "rstmid");
    reset = 1'b0;
    tick();
    if (out_valid !== 0 || fifo_pop !== 0 || out_last !== 0 || err_zero !== 0 ||
        out_data !== 0 || out_idx !== 0 || entries_done !== 0) begin
      $display("FAIL rstmid outputs v=%b p=%b l=%b e=%b d=%h i=%0d n=%0d, required all 0",
               out_valid, fifo_pop, out_last, err_zero, out_data, out_idx, entries_done);
      n_err++;
    end
    n_vec++;
    reset = 1'b1;
    out_ready = 1'b1;
    exp_done = 0;
    for (int k = 0; k < 4; k++) tick();
    check_int(pops - p0, 1, "rstmid pops");
    check_int({31'd0, out_valid}, 0, "rstmid abandoned");
  endtask

  task automatic test_enable();
    int p0;
    p0 = pops; obs.delete();
    out_ready = 1'b0;
    push(31'h3, 8'd2);
    push(31'hC, 8'd1);
    wait_valid(20, "enable");
    enable = 1'b0; out_ready = 1'b1;
    wait_obs(2, 20, "enable");
    for (int k = 0; k < 6; k++) tick();
    check_beat(0, 31'h3, 8'd0, 1'b0, "enable");
    check_beat(1, 31'h3, 8'd1, 1'b1, "enable");
    check_int(obs.size(), 2, "enable parked beats");
    check_int(pops - p0, 1, "enable parked pops");
    check_int({31'd0, out_valid}, 0, "enable parked idle");
    enable = 1'b1;
    wait_obs(3, 20, "enable resume");
    tick(); tick();
    check_beat(2, 31'hC, 8'd0, 1'b1, "enable resume");
    check_int(pops - p0, 2, "enable pops");
    exp_done += 2;
    check_int({16'd0, entries_done}, exp_done, "enable entries_done");
  endtask

  task automatic test_random();
    int p0, pushed, nz, k, stab0, n_ent;
    bit any_zero;
    logic [30:0] d;
    logic [7:0]  c;
    do_reset();
    p0 = pops; stab0 = stab_err; pushed = 0; nz = 0; any_zero = 0; n_ent = 40;
    expq.delete();
    k = 0;
    while (k < 20000) begin
      if (pushed < n_ent && fq.size() < 3 && ($urandom % 2) == 0) begin
        d = 31'($urandom);
        c = (pushed == 7) ? 8'd255 : 8'($urandom_range(0, 5));
        for (int r = 0; r < int'(c); r++)
          expq.push_back('{d: d, i: 8'(r), l: (r == int'(c) - 1), cyc: 0});
        if (c == 0) any_zero = 1; else nz++;
        push(d, c);
        pushed++;
      end
      out_ready = ($urandom % 10) < 7;
      enable    = ($urandom % 10) < 8;
      if (pushed == n_ent && fq.size() == 0 && obs.size() >= expq.size() && out_valid !== 1'b1)
        break;
      tick();
      k++;
    end
    if (k >= 20000) begin
      $display("FAIL random timeout: beats %0d of %0d", obs.size(), expq.size());
      n_err++;
    end
    n_vec++;
    enable = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    check_int(obs.size(), expq.size(), "random beat count");
    for (int b = 0; b < expq.size(); b++)
      check_beat(b, expq[b].d, expq[b].i, expq[b].l, "random");
    check_int(pops - p0, n_ent, "random pops");
    check_int({16'd0, entries_done}, nz % 65536, "random entries_done");
    check_int({31'd0, err_zero}, int'(any_zero), "random err_zero");
    check_int(stab_err - stab0, 0, "random stall stability");
    check_int(pop_on_empty, 0, "pop while empty");
  endtask

  initial begin
    refresh();
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero();
    test_flush();
    test_reset_mid();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
